mux_rr: RTL and testbench
=========================

MUX_RR -- requirements
Module: mux_rr

Interface
REQ-001 Parameter DATA_WIDTH, default 6, bit width of each channel's data word.
REQ-002 Parameter NUM_CH, default 4, number of input channels; legal range 2..8.
REQ-003 Derived CH_W = max(1, clog2(NUM_CH)), the width of the channel-id output.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_L  input  1  reset, synchronous and active-high: the block is in reset when reset_L = 1 at a rising edge of clk.
REQ-006 valid_in  input  NUM_CH  valid_in[i] = 1 means channel i presents a word.
REQ-007 data_in  input  NUM_CH*DATA_WIDTH  flattened channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 out_ready  input  1  downstream accepts data_out when out_ready = 1 and valid_out = 1.
REQ-009 pop  output  NUM_CH  combinational one-hot grant; pop[i] = 1 means channel i's word is consumed this cycle.
REQ-010 valid_out  output  1  registered; data_out and ch_out are meaningful when valid_out = 1.
REQ-011 data_out  output  DATA_WIDTH  registered selected word.
REQ-012 ch_out  output  CH_W  registered index of the channel that sourced data_out.

Function
REQ-013 The output register is loadable (load_en = 1) when valid_out = 0 or out_ready = 1.
REQ-014 When load_en = 1 and any valid_in bit = 1, the arbiter grants exactly one channel g, drives pop = one-hot(g) in the same cycle, and on the next edge loads data_out = channel g word, ch_out = g, valid_out = 1.
REQ-015 When load_en = 1 and valid_in = 0, pop = 0 and valid_out goes to 0 on the next edge; data_out and ch_out hold their values.
REQ-016 When load_en = 0 (stall), pop = 0 and valid_out, data_out and ch_out hold unchanged.
REQ-017 Latency is 1 cycle from grant (pop) to valid_out; sustained throughput is 1 word per cycle when out_ready = 1.
REQ-018 pop shall never have more than one bit set, and shall be 0 for any channel with valid_in = 0.
REQ-019 Arbitration state: pointer rr_ptr (CH_W bits, range 0..NUM_CH-1).
  - Search order: rr_ptr, rr_ptr+1, ... modulo NUM_CH; the first channel with valid_in set is granted.
REQ-020 After a grant to channel g, rr_ptr becomes (g+1) mod NUM_CH, wrapping from NUM_CH-1 to 0; rr_ptr holds when there is no grant.
REQ-021 When valid_out = 1 and out_ready = 1 and a new grant occurs in the same cycle, the old word is retired and the new word is loaded in the same edge without a bubble.
REQ-022 Inputs are level-sampled; a channel held valid across a stall is not lost, and it is granted after the stall according to rr_ptr.

Reset
REQ-023 When reset_L = 1 at an edge, the next state is: valid_out = 0, data_out = 0, ch_out = 0, rr_ptr = 0.
REQ-024 While reset_L = 1, pop shall be 0 regardless of valid_in and out_ready.
REQ-025 Reset asserted mid-transfer discards the held word with no pop; the first grant after reset release follows rr_ptr = 0.

Configuration
REQ-026 Macro MUX_RR_ROUND_ROBIN_EN selects the arbitration scheme.
REQ-027 With MUX_RR_ROUND_ROBIN_EN defined, arbitration is round-robin per REQ-019/REQ-020.
REQ-028 Without MUX_RR_ROUND_ROBIN_EN, arbitration is fixed priority: the lowest-index channel with valid_in set is granted, and rr_ptr is not implemented.
  - All other requirements are unchanged in this mode.

Verification (NUM_CH=4, DATA_WIDTH=6)
REQ-029 Reset:
  - Stimulus: reset_L = 1 for 2 cycles with valid_in = 4'b1111.
  - Required response: pop = 0 throughout; valid_out = 0, data_out = 0, ch_out = 0.
REQ-030 Round-robin fairness (RR enabled):
  - Stimulus: valid_in = 4'b1111 held; data words 0x0A, 0x0B, 0x0C, 0x0D; out_ready = 1.
  - Required response: ch_out sequence 0, 1, 2, 3, 0 on consecutive cycles.
REQ-031 Back-pressure:
  - Stimulus: channel 2 has word 0x15; out_ready = 0 for 3 cycles after valid_out rises.
  - Required response: data_out = 0x15 and ch_out = 2 held stable; pop = 0 during the stall.
  - After out_ready returns to 1, the next grant follows within the same cycle.
REQ-032 Wrap and skip (RR enabled):
  - Stimulus: rr_ptr = 3; valid_in = 4'b0010.
  - Required response: channel 1 is granted; rr_ptr becomes 2.
REQ-033 Fixed priority (macro undefined):
  - Stimulus: valid_in = 4'b1100, held.
  - Required response: channel 2 is granted every cycle; channel 3 is never granted while channel 2 stays valid.
REQ-034 Mid-stream reset:
  - Stimulus: reset_L = 1 asserted while valid_out = 1 and out_ready = 0.
  - Required response: valid_out = 0 on the next edge.
  - After release with valid_in = 4'b1000, the first grant is channel 3.

Source files
------------

// File: rtl/mux_rr_if.sv
// Handshake/data bundle between the channel sources, the mux_rr arbiter and the downstream sink.
interface mux_rr_if #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_CH     = 4
);
  localparam int CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]            valid_in;
  logic [NUM_CH*DATA_WIDTH-1:0] data_in;
  logic                         out_ready;
  logic [NUM_CH-1:0]            pop;
  logic                         valid_out;
  logic [DATA_WIDTH-1:0]        data_out;
  logic [CH_W-1:0]              ch_out;

  modport master (
    output valid_in, data_in, out_ready,
    input  pop, valid_out, data_out, ch_out
  );

  modport slave (
    input  valid_in, data_in, out_ready,
    output pop, valid_out, data_out, ch_out
  );
endinterface

// File: rtl/mux_rr.sv
// N-channel to 1 mux with a single registered output stage and combinational one-hot pop.
// Define MUX_RR_ROUND_ROBIN_EN for round-robin arbitration; default is fixed lowest-index priority.
module mux_rr #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_CH     = 4
) (
  input  logic     clk,
  input  logic     reset_L,
  mux_rr_if.slave  bus
);
  localparam int CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CH_W-1:0]       gnt_ch;
  logic                  any_vld;
  logic                  load_en;
  logic                  grant;
  logic [NUM_CH-1:0]     pop_d;

`ifdef MUX_RR_ROUND_ROBIN_EN
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

  // Scan channels starting at rr_ptr, wrapping modulo NUM_CH; first valid wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_ch  = '0;
    any_vld = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_vld && bus.valid_in[idx]) begin
        any_vld = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
  end
`else
  always_comb begin
    gnt_ch  = '0;
    any_vld = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bus.valid_in[k]) begin
        any_vld = 1'b1;
        gnt_ch  = CH_W'(k);
      end
    end
  end
`endif

  assign load_en = ~vld_q | bus.out_ready;
  assign grant   = load_en & any_vld & ~reset_L;

  always_comb begin
    pop_d = '0;
    if (grant) pop_d[gnt_ch] = 1'b1;
  end

  // Empty or retiring slot refills on the same edge, so no bubble between words.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ch_d   = ch_q;
    if (load_en) begin
      vld_d = any_vld;
      if (any_vld) begin
        data_d = bus.data_in[int'(gnt_ch)*DATA_WIDTH +: DATA_WIDTH];
        ch_d   = gnt_ch;
      end
    end
  end

`ifdef MUX_RR_ROUND_ROBIN_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_L) begin
      vld_q    <= 1'b0;
      data_q   <= '0;
      ch_q     <= '0;
`ifdef MUX_RR_ROUND_ROBIN_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      vld_q    <= vld_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
`ifdef MUX_RR_ROUND_ROBIN_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign bus.pop       = pop_d;
  assign bus.valid_out = vld_q;
  assign bus.data_out  = data_q;
  assign bus.ch_out    = ch_q;
endmodule

// File: tb/tb_mux_rr.sv
// Randomized + directed bench for mux_rr: queue-based arbitration model feeds a scoreboard monitor.
module tb_mux_rr;
  localparam int DW = 6;
  localparam int N  = 4;
  localparam int CW = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } word_t;

  logic clk = 1'b0;
  logic reset_L;

  mux_rr_if #(.DATA_WIDTH(DW), .NUM_CH(N)) bus();
  mux_rr #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (.clk(clk), .reset_L(reset_L), .bus(bus));

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_pass = 0;
  word_t sbq[$];

  bit            m_vld  = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            m_ch   = 0;
  int            m_ptr  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input logic rst, input logic [N-1:0] v, input logic rdy,
                       input logic [N*DW-1:0] d);
    reset_L       = rst;
    bus.valid_in  = v;
    bus.out_ready = rdy;
    bus.data_in   = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Reference model: state is "what the output register holds now"; the channel search
  // walks from the pointer modulo N (pointer pinned at 0 gives fixed priority).
  task automatic model_step();
    logic [N-1:0] epop;
    bit           load;
    int           g;
    int           c;
    epop = '0;
    g    = -1;
    load = !m_vld || (bus.out_ready === 1'b1);
    if (reset_L === 1'b0 && load) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (bus.valid_in[c]) begin
          g = c;
          break;
        end
      end
    end
    if (g >= 0) epop[g] = 1'b1;
    chk("pop", 32'(bus.pop), 32'(epop));
    chk("valid_out", 32'(bus.valid_out), 32'(m_vld));
    if (!m_vld) begin
      chk("data_hold", 32'(bus.data_out), 32'(m_data));
      chk("ch_hold", 32'(bus.ch_out), 32'(m_ch));
    end
    if (reset_L === 1'b1) begin
      m_vld  = 1'b0;
      m_data = '0;
      m_ch   = 0;
      m_ptr  = 0;
      sbq.delete();
    end else if (load) begin
      if (g >= 0) begin
        word_t w;
        w.d    = bus.data_in[g*DW +: DW];
        w.c    = CW'(g);
        m_vld  = 1'b1;
        m_data = w.d;
        m_ch   = g;
        sbq.push_back(w);
`ifdef MUX_RR_ROUND_ROBIN_EN
        m_ptr = (g + 1) % N;
`endif
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  // Scoreboard monitor: every presented word must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_L === 1'b0 && bus.valid_out === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("sb_nonempty", 32'(sbq.size()), 32'd1);
        end else begin
          chk("sb_data", 32'(bus.data_out), 32'(sbq[0].d));
          chk("sb_ch", 32'(bus.ch_out), 32'(sbq[0].c));
          if (bus.out_ready === 1'b1) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [N*DW-1:0] abcd;
    logic [N*DW-1:0] w15;
    abcd = {6'h0D, 6'h0C, 6'h0B, 6'h0A};
    w15  = {6'h01, 6'h15, 6'h02, 6'h03};

    // reset with all channels requesting
    drive(1'b1, 4'b1111, 1'b1, abcd);
    drive(1'b1, 4'b1111, 1'b1, abcd);
    // fairness run
    for (int i = 0; i < 5; i++) drive(1'b0, 4'b1111, 1'b1, abcd);
    drive(1'b0, 4'b0000, 1'b1, abcd);
    // back-pressure on channel 2's word
    drive(1'b0, 4'b0100, 1'b1, w15);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b0100, 1'b0, w15);
    drive(1'b0, 4'b0100, 1'b1, w15);
    // pointer at 3 after channel 2 grant, then wrap/skip to channel 1
    drive(1'b0, 4'b0010, 1'b1, abcd);
    drive(1'b0, 4'b1111, 1'b1, abcd);
    drive(1'b0, 4'b0000, 1'b1, abcd);
    // priority between channels 2 and 3
    for (int i = 0; i < 4; i++) drive(1'b0, 4'b1100, 1'b1, rnd_data());
    // mid-stream reset with a stalled word
    drive(1'b0, 4'b0100, 1'b0, w15);
    drive(1'b0, 4'b0000, 1'b0, w15);
    drive(1'b1, 4'b0100, 1'b0, w15);
    drive(1'b0, 4'b1000, 1'b1, abcd);
    drive(1'b0, 4'b1000, 1'b1, abcd);
    drive(1'b0, 4'b0000, 1'b1, abcd);
    // random traffic
    for (int i = 0; i < 400; i++)
      drive(($urandom % 50) == 0, N'($urandom), ($urandom % 4) != 0, rnd_data());
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b0000, 1'b1, abcd);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
